// File: rtl/pin_entry_tx.sv
// Keypad-side PIN transmitter: collects two decimal digits, converts them to binary,
// and shifts the PIN out MSB-first on a framed serial line.
module pin_entry_tx #(
  parameter int PIN_W       = 8,
  parameter int BIT_CYC     = 1,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       pin,
  output logic       pin_frame,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       entry_err,
  output logic       entry_tmo,
  output logic [1:0] digit_cnt,
  output logic [2:0] state_dbg
);

  localparam int PER_W = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam int BIT_W = $clog2(PIN_W);
  localparam int TMO_W = $clog2(TIMEOUT_CYC);

  localparam logic [PER_W-1:0] PER_LAST = PER_W'(BIT_CYC - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PIN_W - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [PIN_W-1:0] TEN      = PIN_W'(10);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ONE  = 3'd1,
    TWO  = 3'd2,
    SEND = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t             state, state_n;
  logic [PIN_W-1:0]   acc, acc_n;
  logic [BIT_W-1:0]   bit_cnt, bit_n;
  logic [PER_W-1:0]   per_cnt, per_n;
  logic [TMO_W-1:0]   tmo_cnt, tmo_n;
  logic               err_q, err_n;
  logic               tmo_q, tmo_pulse_n;

  // key_valid is a one-cycle strobe with no back-pressure: a key is consumed on the
  // edge where key_valid is high, and keys arriving in SEND or DONE are discarded.
  logic is_digit, is_clear, is_enter;
  assign is_digit = (key_code <= 4'd9);
  assign is_clear = (key_code == 4'hA);
  assign is_enter = (key_code == 4'hB);

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      acc     <= '0;
      bit_cnt <= '0;
      per_cnt <= '0;
      tmo_cnt <= '0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state   <= state_n;
      acc     <= acc_n;
      bit_cnt <= bit_n;
      per_cnt <= per_n;
      tmo_cnt <= tmo_n;
      err_q   <= err_n;
      tmo_q   <= tmo_pulse_n;
    end
  end

  always_comb begin
    state_n     = state;
    acc_n       = acc;
    bit_n       = bit_cnt;
    per_n       = per_cnt;
    tmo_n       = tmo_cnt;
    err_n       = 1'b0;
    tmo_pulse_n = 1'b0;
    case (state)
      IDLE: begin
        tmo_n = '0;
        if (key_valid) begin
          if (is_digit) begin
            acc_n   = {{(PIN_W-4){1'b0}}, key_code};
            state_n = ONE;
          end else if (is_clear) begin
            acc_n = '0;
          end else begin
            err_n = 1'b1;
            if (is_enter) acc_n = '0;
          end
        end
      end
      ONE, TWO: begin
        if (key_valid) begin
          // Any key restarts the idle window and beats a same-cycle expiry.
          tmo_n = '0;
          if (is_digit) begin
            if (state == ONE) begin
              acc_n   = acc * TEN + {{(PIN_W-4){1'b0}}, key_code};
              state_n = TWO;
            end else begin
              err_n = 1'b1;
            end
          end else if (is_clear) begin
            acc_n   = '0;
            state_n = IDLE;
          end else if (is_enter) begin
            if (state == TWO) begin
              bit_n   = '0;
              per_n   = '0;
              state_n = SEND;
            end else begin
              err_n   = 1'b1;
              acc_n   = '0;
              state_n = IDLE;
            end
          end else begin
            err_n = 1'b1;
          end
        end else if (tmo_cnt == TMO_LAST) begin
          tmo_pulse_n = 1'b1;
          tmo_n       = '0;
          acc_n       = '0;
          state_n     = IDLE;
        end else begin
          tmo_n = tmo_cnt + 1'b1;
        end
      end
      SEND: begin
        if (per_cnt == PER_LAST) begin
          per_n = '0;
          acc_n = {acc[PIN_W-2:0], 1'b0};
          if (bit_cnt == BIT_LAST) state_n = DONE;
          else                     bit_n   = bit_cnt + 1'b1;
        end else begin
          per_n = per_cnt + 1'b1;
        end
      end
      DONE: begin
        acc_n   = '0;
        state_n = IDLE;
      end
      default: begin
        acc_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  assign pin_frame = (state == SEND);
  assign tx_busy   = pin_frame;
  assign pin       = pin_frame & acc[PIN_W-1];
  assign tx_done   = (state == DONE);
  assign entry_err = err_q;
  assign entry_tmo = tmo_q;
  assign digit_cnt = (state == ONE) ? 2'd1 : (state == TWO) ? 2'd2 : 2'd0;
  assign state_dbg = state;

endmodule

// File: tb/tb_pin_entry_tx.sv
// Bench for pin_entry_tx: two instances (1- and 3-cycle bit periods) driven from one
// key stream, checked against a digit-queue model of the keypad rules.
module tb_pin_entry_tx;

  localparam int PIN_W = 8;
  localparam int TMO   = 16;

  logic       clock = 1'b0;
  logic       reset;
  logic       kv;
  logic [3:0] kc;
  logic       sel3;

  logic       kv_a, kv_b;
  logic       pin_a, frame_a, busy_a, done_a, err_a, tmo_a;
  logic       pin_b, frame_b, busy_b, done_b, err_b, tmo_b;
  logic [1:0] cnt_a, cnt_b;
  logic [2:0] st_a, st_b;

  logic       o_pin, o_frame, o_busy, o_done, o_err, o_tmo;
  logic [1:0] o_cnt;
  logic [2:0] o_st;

  // clock / reset
  always #5 clock = ~clock;

  assign kv_a = kv & ~sel3;
  assign kv_b = kv & sel3;

  pin_entry_tx #(.PIN_W(PIN_W), .BIT_CYC(1), .TIMEOUT_CYC(TMO)) dut_a (
    .clock(clock), .reset(reset), .key_valid(kv_a), .key_code(kc),
    .pin(pin_a), .pin_frame(frame_a), .tx_busy(busy_a), .tx_done(done_a),
    .entry_err(err_a), .entry_tmo(tmo_a), .digit_cnt(cnt_a), .state_dbg(st_a));

  pin_entry_tx #(.PIN_W(PIN_W), .BIT_CYC(3), .TIMEOUT_CYC(TMO)) dut_b (
    .clock(clock), .reset(reset), .key_valid(kv_b), .key_code(kc),
    .pin(pin_b), .pin_frame(frame_b), .tx_busy(busy_b), .tx_done(done_b),
    .entry_err(err_b), .entry_tmo(tmo_b), .digit_cnt(cnt_b), .state_dbg(st_b));

  assign o_pin   = sel3 ? pin_b   : pin_a;
  assign o_frame = sel3 ? frame_b : frame_a;
  assign o_busy  = sel3 ? busy_b  : busy_a;
  assign o_done  = sel3 ? done_b  : done_a;
  assign o_err   = sel3 ? err_b   : err_a;
  assign o_tmo   = sel3 ? tmo_b   : tmo_a;
  assign o_cnt   = sel3 ? cnt_b   : cnt_a;
  assign o_st    = sel3 ? st_b    : st_a;

  // scoreboard / model state
  logic [PIN_W-1:0] exp_q[$];
  int digits[$];
  int idle_cnt;
  int total;
  int bad;
  bit auto_cap;
  bit noise;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic model_key(input logic [3:0] c, output bit err, output bit send);
    err  = 1'b0;
    send = 1'b0;
    if (c <= 4'd9) begin
      if (digits.size() < 2) digits.push_back(int'(c));
      else err = 1'b1;
    end else if (c == 4'hA) begin
      digits.delete();
    end else if (c == 4'hB) begin
      if (digits.size() == 2) begin
        exp_q.push_back(PIN_W'(digits[0] * 10 + digits[1]));
        send = 1'b1;
      end else begin
        err = 1'b1;
      end
      digits.delete();
    end else begin
      err = 1'b1;
    end
  endtask

  task automatic capture();
    logic [PIN_W-1:0] e;
    int bc;
    bc = sel3 ? 3 : 1;
    e  = exp_q.pop_front();
    for (int k = 0; k < PIN_W; k++) begin
      for (int c = 0; c < bc; c++) begin
        check("frame_high", o_frame, 1);
        check("busy_high", o_busy, 1);
        check("pin_bit", o_pin, e[PIN_W-1-k]);
        check("done_in_frame", o_done, 0);
        check("err_in_frame", o_err, 0);
        check("cnt_in_frame", o_cnt, 0);
        if (noise && $urandom_range(0, 2) == 0) begin
          kv = 1'b1;
          kc = 4'($urandom_range(0, 15));
        end
        tick();
        kv = 1'b0;
      end
    end
    check("frame_end", o_frame, 0);
    check("pin_end", o_pin, 0);
    check("done_pulse", o_done, 1);
    check("err_at_done", o_err, 0);
    tick();
    check("done_one_cycle", o_done, 0);
    check("cnt_after_done", o_cnt, 0);
  endtask

  // driver: one key strobe, then the model's view of the following cycle
  task automatic press(input logic [3:0] c);
    bit err;
    bit send;
    model_key(c, err, send);
    kc = c;
    kv = 1'b1;
    tick();
    kv = 1'b0;
    idle_cnt = 0;
    check("key_err", o_err, err);
    check("key_cnt", o_cnt, digits.size());
    check("key_no_tmo", o_tmo, 0);
    if (send && auto_cap) capture();
  endtask

  task automatic idle(input int n);
    bit exp_tmo;
    repeat (n) begin
      tick();
      exp_tmo = 1'b0;
      if (digits.size() > 0) begin
        idle_cnt++;
        if (idle_cnt == TMO) begin
          exp_tmo = 1'b1;
          digits.delete();
          idle_cnt = 0;
        end
      end
      check("idle_tmo", o_tmo, exp_tmo);
      check("idle_cnt", o_cnt, digits.size());
      check("idle_err", o_err, 0);
    end
  endtask

  task automatic random_keys(input int n);
    int r;
    logic [3:0] c;
    repeat (n) begin
      r = $urandom_range(0, 99);
      if (r < 60)      c = 4'($urandom_range(0, 9));
      else if (r < 75) c = 4'hB;
      else if (r < 85) c = 4'hA;
      else             c = 4'($urandom_range(12, 15));
      press(c);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 20));
    end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    idle_cnt = 0;
    auto_cap = 1'b1;
    noise    = 1'b0;
    reset    = 1'b1;
    kv       = 1'b0;
    kc       = 4'h0;
    sel3     = 1'b0;
    repeat (3) tick();

    // reset state of both instances
    for (int s = 0; s < 2; s++) begin
      sel3 = s[0];
      #1;
      check("rst_pin", o_pin, 0);
      check("rst_frame", o_frame, 0);
      check("rst_busy", o_busy, 0);
      check("rst_done", o_done, 0);
      check("rst_err", o_err, 0);
      check("rst_tmo", o_tmo, 0);
      check("rst_cnt", o_cnt, 0);
      check("rst_state", o_st, 0);
    end
    sel3  = 1'b0;
    reset = 1'b0;
    tick();

    // 72 at one cycle per bit
    press(4'd7); press(4'd2); press(4'hB);
    // enter after one digit is rejected, then a clean entry
    press(4'd4); press(4'hB);
    check("short_no_frame", o_frame, 0);
    press(4'd7); press(4'd2); press(4'hB);
    // invalid key, clear, third-digit rejection
    press(4'd9); press(4'hC); press(4'hA); press(4'd3);
    press(4'd4); press(4'd5); press(4'hB);
    // timeout, and a key on the expiry cycle beating it
    press(4'd7); idle(TMO);
    press(4'd7); idle(TMO - 1); press(4'd2); idle(TMO);
    // reset a few cycles into a frame
    auto_cap = 1'b0;
    press(4'd7); press(4'd2); press(4'hB);
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    void'(exp_q.pop_front());
    digits.delete();
    check("abort_pin", o_pin, 0);
    check("abort_frame", o_frame, 0);
    check("abort_done", o_done, 0);
    check("abort_state", o_st, 0);
    repeat (12) begin
      tick();
      check("abort_no_done", o_done, 0);
      check("abort_no_frame", o_frame, 0);
    end
    auto_cap = 1'b1;

    // three cycles per bit, keys pressed mid-frame
    sel3  = 1'b1;
    noise = 1'b1;
    #1;
    press(4'd0); press(4'd5); press(4'hB);
    random_keys(40);
    press(4'hA);

    // randomized run at one cycle per bit
    sel3 = 1'b0;
    #1;
    random_keys(60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
